// File: rtl/wifi_phy_pkg.sv
// Shared 802.11a PHY definitions: modulation encoding and coded-bits-per-symbol lookups.
package wifi_phy_pkg;

    localparam int NMAX   = 288;
    localparam int ADDR_W = 9;

    typedef enum logic [1:0] {
        MOD_BPSK  = 2'd0,
        MOD_QPSK  = 2'd1,
        MOD_16QAM = 2'd2,
        MOD_64QAM = 2'd3
    } mod_t;

    function automatic logic [ADDR_W-1:0] n_cbps(input mod_t m);
        case (m)
            MOD_BPSK:  return 9'd48;
            MOD_QPSK:  return 9'd96;
            MOD_16QAM: return 9'd192;
            default:   return 9'd288;
        endcase
    endfunction

    // Column stride of the first permutation (N_CBPS / 16).
    function automatic logic [4:0] n_cbps_div16(input mod_t m);
        case (m)
            MOD_BPSK:  return 5'd3;
            MOD_QPSK:  return 5'd6;
            MOD_16QAM: return 5'd12;
            default:   return 5'd18;
        endcase
    endfunction

endpackage

// File: rtl/il_addr_gen.sv
// Combinational 802.11a interleaver address: natural index k -> interleaved position j.
// Shared with the receive de-interleaver model.
module il_addr_gen
    import wifi_phy_pkg::*;
(
    input  logic [8:0] k_i,
    input  logic [1:0] mod_i,
    output logic [8:0] j_o
);

    mod_t       m;
    logic [8:0] i_perm;
    logic [8:0] quot12;
    logic [8:0] quot18;
    logic [8:0] base3;
    logic [8:0] rem3;

    always_comb begin
        m      = mod_t'(mod_i);
        i_perm = {4'd0, n_cbps_div16(m)} * {5'd0, k_i[3:0]} + {4'd0, k_i[8:4]};
        quot12 = i_perm / 9'd12;
        quot18 = i_perm / 9'd18;
        base3  = (i_perm / 9'd3) * 9'd3;
        rem3   = (i_perm - quot18) % 9'd3;
        // Second permutation rotates bits within each group of s = N_BPSC/2 adjacent positions.
        case (m)
            MOD_16QAM: j_o = i_perm ^ (quot12 & 9'd1);
            MOD_64QAM: j_o = base3 + rem3;
            default:   j_o = i_perm;
        endcase
    end

endmodule

// File: rtl/tx_interleaver.sv
// 802.11a transmit block interleaver with ping-pong banks: one symbol fills while the other drains.
// Optional build macro TX_IL_SYMCNT_EN adds the sym_count output (symbols fully emitted).
module tx_interleaver
    import wifi_phy_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  mod,
    input  logic        in_valid,
    input  logic        in_bit,
    output logic        in_ready,
    output logic        out_valid,
    output logic        out_bit,
    input  logic        out_ready,
    output logic        out_last
`ifdef TX_IL_SYMCNT_EN
    ,
    output logic [15:0] sym_count
`endif
);

    logic [ADDR_W-1:0] k_q, k_d;
    logic [ADDR_W-1:0] r_q, r_d;
    logic              wb_q, wb_d;
    logic              rb_q, rb_d;
    logic [1:0]        full_q, full_d;
    mod_t              bank_mod_q [2];
    logic [NMAX-1:0]   mem_q [2];

    mod_t              wr_mod;
    mod_t              rd_mod;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_fire, rd_fire;
    logic              wr_done, rd_at_last;

    // The first bit of a symbol takes its mode from the port; later bits follow the captured mode.
    assign wr_mod     = (k_q == '0) ? mod_t'(mod) : bank_mod_q[wb_q];
    assign rd_mod     = bank_mod_q[rb_q];
    assign wr_done    = (k_q == n_cbps(wr_mod) - 9'd1);
    assign rd_at_last = (r_q == n_cbps(rd_mod) - 9'd1);

    assign in_ready  = ~full_q[wb_q];
    assign out_valid = full_q[rb_q];
    assign out_bit   = mem_q[rb_q][r_q];
    assign out_last  = out_valid & rd_at_last;

    assign wr_fire = in_valid & in_ready;
    assign rd_fire = out_valid & out_ready;

    il_addr_gen u_addr_gen (
        .k_i   (k_q),
        .mod_i (wr_mod),
        .j_o   (wr_addr)
    );

    always_comb begin
        k_d    = k_q;
        r_d    = r_q;
        wb_d   = wb_q;
        rb_d   = rb_q;
        full_d = full_q;
        if (wr_fire) begin
            if (wr_done) begin
                k_d          = '0;
                wb_d         = ~wb_q;
                full_d[wb_q] = 1'b1;
            end else begin
                k_d = k_q + 9'd1;
            end
        end
        // A completing write and a completing read always target different banks.
        if (rd_fire) begin
            if (rd_at_last) begin
                r_d          = '0;
                rb_d         = ~rb_q;
                full_d[rb_q] = 1'b0;
            end else begin
                r_d = r_q + 9'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k_q    <= '0;
            r_q    <= '0;
            wb_q   <= 1'b0;
            rb_q   <= 1'b0;
            full_q <= 2'b00;
        end else begin
            k_q    <= k_d;
            r_q    <= r_d;
            wb_q   <= wb_d;
            rb_q   <= rb_d;
            full_q <= full_d;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                bank_mod_q[gi] <= MOD_BPSK;
            end else if (wr_fire && (k_q == '0) && (wb_q == 1'(gi))) begin
                bank_mod_q[gi] <= mod_t'(mod);
            end
        end

        // Bit storage is deliberately left out of reset.
        always_ff @(posedge clk) begin
            if (wr_fire && (wb_q == 1'(gi))) begin
                mem_q[gi][wr_addr] <= in_bit;
            end
        end
    end

`ifdef TX_IL_SYMCNT_EN
    logic [15:0] sym_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sym_cnt_q <= '0;
        end else if (rd_fire && rd_at_last) begin
            sym_cnt_q <= sym_cnt_q + 16'd1;
        end
    end

    assign sym_count = sym_cnt_q;
`endif

endmodule
